// File: rtl/nibble_rx_pkg.sv
// Shared definitions for the nibble serial receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a; the receiver has no flow control, the line cannot be stalled.
//
// Contents: FSM state encoding, nibble width, default oversampling ratio.
package nibble_rx_pkg;

  // Width of one received data word.
  localparam int NIBBLE_W = 4;

  // Default clock cycles per serial bit (must be even and at least 4).
  localparam int CLKS_PER_BIT_DEF = 16;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/nibble_serial_rx_sync_2ff.sv
// One-bit two-flop synchronizer with a configurable reset level.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; samples every cycle.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset; both flops load RESET_VAL
//   d      asynchronous input
//   q      synchronized output
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nibble_serial_rx.sv
// UART-style nibble receiver: start bit, 4 data bits LSB first, stop bit.
// Latency: load/frame_err strobe 1 cycle after the mid-stop sample (t0+H+5N+1).
// Backpressure: none; the line is free-running, a good frame always loads.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   rx         asynchronous serial line, idles high
//   data_out   last correctly framed nibble (bit 0 = first data bit)
//   load       one-cycle strobe, data_out newly updated this cycle
//   frame_err  one-cycle strobe, stop bit was low and the frame was dropped
//   busy       high whenever the FSM is not idle
module nibble_serial_rx
  import nibble_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx,
  output logic [NIBBLE_W-1:0] data_out,
  output logic                load,
  output logic                frame_err,
  output logic                busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [1:0]    IDX_LAST = 2'(NIBBLE_W - 1);

  logic                rx_s;
  rx_state_t           state;
  logic [CW-1:0]       cnt;
  logic [1:0]          idx;
  logic [NIBBLE_W-1:0] shreg;

  // Reset to the idle (high) level so reset never fakes a start bit.
  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data_out  <= '0;
      load      <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      load      <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= S_START;
            busy  <= 1'b1;
          end
        end

        // Check the line again half a bit in; a high level here means the
        // falling edge was a glitch, not a start bit.
        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= S_DATA;
              idx   <= '0;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // The counter was re-aligned to mid-bit in START, so a full-bit
        // count lands every data sample in the middle of its bit.
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt        <= '0;
            shreg[idx] <= rx_s;
            if (idx == IDX_LAST) begin
              state <= S_STOP;
            end else begin
              idx <= idx + 2'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              data_out <= shreg;
              load     <= 1'b1;
              state    <= S_IDLE;
              busy     <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // A line held low after a bad stop bit must not be re-read as a
        // stream of new start bits; wait for it to return high first.
        S_BREAK: begin
          cnt <= '0;
          if (rx_s) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
